// File: rtl/sr_latch_driver.sv
// Command-to-strobe stage driving the active-low S/R inputs of an SR latch,
// with readback check. Define SR_LATCH_DRIVER_SYNC_EN to synchronize Q/Qn readback.
module sr_latch_driver #(
  parameter int PULSE_CYCLES  = 2,
  parameter int SETTLE_CYCLES = 3,
  parameter int CNT_W         = 4,
  parameter int ERRCNT_W      = 8
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                CmdValid,
  input  logic                CmdSet,
  output logic                CmdReady,
  output logic                S_n,
  output logic                R_n,
  input  logic                Q_in,
  input  logic                Qn_in,
  output logic                Done,
  output logic                Error,
  output logic [ERRCNT_W-1:0] ErrCount
);

`ifdef SR_LATCH_DRIVER_SYNC_EN
  localparam int SYNC_STAGES = 2;
  localparam int CW          = CNT_W + 1;
`else
  localparam int SYNC_STAGES = 0;
  localparam int CW          = CNT_W;
`endif

  localparam logic [CW-1:0] PULSE_LOAD  = CW'(PULSE_CYCLES - 1);
  localparam logic [CW-1:0] SETTLE_LOAD = CW'(SETTLE_CYCLES - 1 + SYNC_STAGES);

  typedef enum logic [1:0] {IDLE, PULSE, SETTLE, CHECK} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic          cmd_set;
  logic          q_chk;
  logic          qn_chk;
  logic          mismatch;

`ifdef SR_LATCH_DRIVER_SYNC_EN
  logic [1:0] q_sync;
  logic [1:0] qn_sync;

  // Synchronizer flops carry no reset: their contents are flushed long before
  // any CHECK can follow a reset, so a reset term would only add logic.
  always_ff @(posedge Clk) begin
    q_sync  <= {q_sync[0], Q_in};
    qn_sync <= {qn_sync[0], Qn_in};
  end

  assign q_chk  = q_sync[1];
  assign qn_chk = qn_sync[1];
`else
  // Direct sample: the latch has been static for SETTLE_CYCLES before CHECK.
  assign q_chk  = Q_in;
  assign qn_chk = Qn_in;
`endif

  assign mismatch = ({q_chk, qn_chk} != {cmd_set, ~cmd_set});

  // NOTE: every register here uses non-blocking assignment so all of them
  // update together from the pre-edge values, matching the hardware.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      cnt      <= '0;
      cmd_set  <= 1'b0;
      CmdReady <= 1'b0;
      S_n      <= 1'b1;
      R_n      <= 1'b1;
      Done     <= 1'b0;
      Error    <= 1'b0;
      ErrCount <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        IDLE: begin
          if (CmdValid && CmdReady) begin
            cmd_set  <= CmdSet;
            CmdReady <= 1'b0;
            Error    <= 1'b0;
            cnt      <= PULSE_LOAD;
            state    <= PULSE;
          end else begin
            CmdReady <= 1'b1;
          end
        end
        PULSE: begin
          // Only the strobe selected by the latched command can go low.
          S_n <= ~cmd_set;
          R_n <= cmd_set;
          if (cnt == '0) begin
            cnt   <= SETTLE_LOAD;
            state <= SETTLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        SETTLE: begin
          S_n <= 1'b1;
          R_n <= 1'b1;
          if (cnt == '0) begin
            state <= CHECK;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        CHECK: begin
          Done     <= 1'b1;
          Error    <= mismatch;
          CmdReady <= 1'b1;
          state    <= IDLE;
          if (mismatch && (ErrCount != '1)) begin
            ErrCount <= ErrCount + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sr_latch_driver.sv
// Self-checking bench for sr_latch_driver: behavioural latch, timeline-based
// reference model, per-cycle comparison and directed literal checks.
module tb_sr_latch_driver;

  localparam int P = 2;
  localparam int S = 3;
`ifdef SR_LATCH_DRIVER_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif
  localparam int L      = P + S + 1 + SYNC;
  localparam int ERRMAX = 255;

  logic       Clk = 1'b0;
  logic       Reset, CmdValid, CmdSet;
  logic       CmdReady, S_n, R_n, Q_in, Qn_in, Done, Error;
  logic [7:0] ErrCount;

  always #5 Clk = ~Clk;

  sr_latch_driver #(
    .PULSE_CYCLES(P), .SETTLE_CYCLES(S), .CNT_W(4), .ERRCNT_W(8)
  ) dut (
    .Clk(Clk), .Reset(Reset), .CmdValid(CmdValid), .CmdSet(CmdSet),
    .CmdReady(CmdReady), .S_n(S_n), .R_n(R_n), .Q_in(Q_in), .Qn_in(Qn_in),
    .Done(Done), .Error(Error), .ErrCount(ErrCount)
  );

  // Behavioural SR latch, responding 2 ns after the strobe edge, plus a
  // fault override that pins the readback to chosen values.
  logic lq, force_en, fq, fqn;
  always @(posedge Clk) begin
    #2;
    if (!S_n) lq <= 1'b1;
    else if (!R_n) lq <= 1'b0;
  end
  assign Q_in  = force_en ? fq  : lq;
  assign Qn_in = force_en ? fqn : ~lq;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic mis_f(input logic cmd, input logic q, input logic qn);
    return {q, qn} != {cmd, ~cmd};
  endfunction

  // Reference model: each accepted command is a timeline measured in edges
  // from its accept edge k: strobe low at k+1..k+P, result at k+L.
  int   ecount = 0;
  int   m_k = 0;
  int   m_cnt = 0;
  logic m_started = 1'b0;
  logic m_active = 1'b0, m_cmd = 1'b0, m_ready = 1'b0;
  logic m_done = 1'b0, m_err = 1'b0, m_sn = 1'b1, m_rn = 1'b1;
  logic [1:0] qh = 2'b00, qnh = 2'b00;
  logic samp_q, samp_qn;

  assign samp_q  = (SYNC != 0) ? qh[1]  : Q_in;
  assign samp_qn = (SYNC != 0) ? qnh[1] : Qn_in;

  always @(posedge Clk) begin
    m_started <= 1'b1;
    ecount    <= ecount + 1;
    qh        <= {qh[0], Q_in};
    qnh       <= {qnh[0], Qn_in};
    if (Reset) begin
      m_active <= 1'b0;
      m_ready  <= 1'b0;
      m_done   <= 1'b0;
      m_err    <= 1'b0;
      m_cnt    <= 0;
      m_sn     <= 1'b1;
      m_rn     <= 1'b1;
    end else begin
      m_done <= 1'b0;
      m_sn   <= 1'b1;
      m_rn   <= 1'b1;
      if (!m_active) begin
        if (m_ready && CmdValid) begin
          m_active <= 1'b1;
          m_k      <= ecount;
          m_cmd    <= CmdSet;
          m_ready  <= 1'b0;
          m_err    <= 1'b0;
        end else begin
          m_ready <= 1'b1;
        end
      end else begin
        if ((ecount - m_k) >= 1 && (ecount - m_k) <= P) begin
          m_sn <= ~m_cmd;
          m_rn <= m_cmd;
        end
        if ((ecount - m_k) == L) begin
          m_done   <= 1'b1;
          m_err    <= mis_f(m_cmd, samp_q, samp_qn);
          m_ready  <= 1'b1;
          m_active <= 1'b0;
          if (mis_f(m_cmd, samp_q, samp_qn) && m_cnt < ERRMAX) m_cnt <= m_cnt + 1;
        end
      end
    end
  end

  always @(negedge Clk) begin
    if (m_started) begin
      check("ready", CmdReady, m_ready);
      check("s_n", S_n, m_sn);
      check("r_n", R_n, m_rn);
      check("done", Done, m_done);
      check("error", Error, m_err);
      check("errcount", ErrCount, m_cnt);
      check("never_both_low", (S_n | R_n), 1'b1);
    end
  end

  logic sn_h[0:15], rn_h[0:15], dn_h[0:15], er_h[0:15];

  task automatic record_window();
    for (int i = 1; i <= L; i++) begin
      @(negedge Clk);
      CmdValid = 1'b0;
      sn_h[i] = S_n;
      rn_h[i] = R_n;
      dn_h[i] = Done;
      er_h[i] = Error;
    end
  endtask

  initial begin
    int dones, sn_low, budget, gap;
    logic hold;
    Reset = 1'b1; CmdValid = 1'b0; CmdSet = 1'b0;
    force_en = 1'b0; fq = 1'b0; fqn = 1'b0; lq = 1'b0;

    // Reset held for 3 edges, then first edge after release raises CmdReady.
    repeat (3) @(negedge Clk);
    check("rst_ready", CmdReady, 1'b0);
    check("rst_s_n", S_n, 1'b1);
    check("rst_r_n", R_n, 1'b1);
    check("rst_errcount", ErrCount, 8'd0);
    Reset = 1'b0;
    @(negedge Clk);
    check("ready_after_release", CmdReady, 1'b1);

    // Set into the behavioural latch.
    CmdValid = 1'b1; CmdSet = 1'b1;
    @(negedge Clk);
    check("set_accept_s_n", S_n, 1'b1);
    record_window();
    check("set_s_n_k1", sn_h[1], 1'b0);
    check("set_s_n_kP", sn_h[P], 1'b0);
    check("set_s_n_release", sn_h[P+1], 1'b1);
    check("set_no_early_done", dn_h[L-1], 1'b0);
    check("set_done", dn_h[L], 1'b1);
    check("set_error", er_h[L], 1'b0);
    check("set_q", {Q_in, Qn_in}, 2'b10);

    // Clear issued while the set's Done is visible.
    CmdValid = 1'b1; CmdSet = 1'b0;
    @(negedge Clk);
    record_window();
    sn_low = 0;
    for (int i = 1; i <= L; i++) if (!sn_h[i]) sn_low++;
    check("clr_r_n_k1", rn_h[1], 1'b0);
    check("clr_r_n_k2", rn_h[2], 1'b0);
    check("clr_r_n_release", rn_h[3], 1'b1);
    check("clr_s_n_never_low", sn_low, 0);
    check("clr_done", dn_h[L], 1'b1);
    check("clr_error", er_h[L], 1'b0);
    check("clr_q", {Q_in, Qn_in}, 2'b01);

    // Reset while the set strobe is low: aborted, no Done.
    CmdValid = 1'b1; CmdSet = 1'b1;
    @(negedge Clk);
    CmdValid = 1'b0;
    @(negedge Clk);
    check("midrst_s_n_low", S_n, 1'b0);
    Reset = 1'b1;
    @(negedge Clk);
    check("midrst_s_n_high", S_n, 1'b1);
    check("midrst_done", Done, 1'b0);
    Reset = 1'b0;
    dones = 0;
    for (int i = 0; i < L + 2; i++) begin
      @(negedge Clk);
      if (Done) dones++;
      if (i == 0) check("midrst_ready", CmdReady, 1'b1);
    end
    check("midrst_no_done", dones, 0);

    // CmdValid held through the busy window: exactly one command completes.
    CmdValid = 1'b1; CmdSet = 1'b0;
    @(negedge Clk);
    dones = 0;
    for (int i = 1; i <= L; i++) begin
      CmdSet = 1'($urandom_range(0, 1));
      @(negedge Clk);
      if (Done) dones++;
    end
    CmdValid = 1'b0;
    check("held_valid_one_done", dones, 1);
    repeat (2) @(negedge Clk);

    // Randomized commands, fault overrides, back-to-back issue and resets.
    for (int n = 0; n < 150; n++) begin
      force_en = ($urandom_range(0, 3) == 0);
      fq       = 1'($urandom_range(0, 1));
      fqn      = 1'($urandom_range(0, 1));
      hold     = 1'($urandom_range(0, 1));
      CmdValid = 1'b1;
      CmdSet   = 1'($urandom_range(0, 1));
      budget   = 0;
      do begin
        @(negedge Clk);
        budget++;
      end while (!m_active && budget < 20);
      if (!m_active) check("accept_timeout", 1'b0, 1'b1);
      budget = 0;
      do begin
        CmdValid = hold;
        CmdSet   = 1'($urandom_range(0, 1));
        if (m_active && $urandom_range(0, 99) < 3) begin
          Reset = 1'b1;
          @(negedge Clk);
          Reset = 1'b0;
        end else begin
          @(negedge Clk);
        end
        budget++;
      end while (m_active && budget < 40);
      if (m_active) check("done_timeout", 1'b0, 1'b1);
      CmdValid = 1'b0;
      gap = $urandom_range(0, 3);
      repeat (gap) @(negedge Clk);
    end
    force_en = 1'b0;

    // Readback pinned to (0,0): every set fails; ErrCount saturates.
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    @(negedge Clk);
    force_en = 1'b1; fq = 1'b0; fqn = 1'b0;
    CmdValid = 1'b1; CmdSet = 1'b1;
    budget = 0;
    do begin
      @(negedge Clk);
      budget++;
    end while (!Done && budget < 40);
    check("fault_done", Done, 1'b1);
    check("fault_error", Error, 1'b1);
    check("fault_errcount", ErrCount, 8'd1);
    dones = 1;
    budget = 0;
    while (dones < 300 && budget < 300 * (L + 2)) begin
      @(negedge Clk);
      budget++;
      if (Done) dones++;
    end
    CmdValid = 1'b0;
    check("fault_count_300", dones, 300);
    check("fault_saturate", ErrCount, 8'd255);
    repeat (L + 2) @(negedge Clk);
    check("fault_no_wrap", ErrCount, 8'd255);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Synchronous command-to-strobe stage that sits directly upstream of the SR latch and drives its active-low S and R inputs.
- Accepts set/clear commands over a valid/ready handshake and generates a timed strobe on S_n or R_n.
- Waits for the latch to settle, then reads Q/Qn back and reports pass or fail.
- Never drives S_n and R_n low at the same time.

Parameters:
- PULSE_CYCLES, 2: Clk cycles the strobe is held low; legal range 1..2^CNT_W-1.
- SETTLE_CYCLES, 3: Clk cycles between strobe release and readback sample; legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the internal cycle counter.
- ERRCNT_W, 8: width of the error counter.

Ports:
- Clk  input  1  rising-edge clock; 10 ns nominal period.
- Reset  input  1  synchronous, active-high reset.
- CmdValid  input  1  command present.
- CmdSet  input  1  1 = set latch (Q=1), 0 = clear latch (Q=0); qualified by CmdValid.
- CmdReady  output  1  block can accept a command this cycle.
- S_n  output  1  to latch S; low = set strobe.
- R_n  output  1  to latch R; low = clear strobe.
- Q_in  input  1  latch Q readback; asynchronous to Clk.
- Qn_in  input  1  latch Qn readback; asynchronous to Clk.
- Done  output  1  one-cycle pulse: check complete.
- Error  output  1  result of last check; valid from Done, held until next accept.
- ErrCount  output  ERRCNT_W  saturating count of failed checks.

Behaviour:
- Clock and reset: one clock, Clk. Reset is synchronous and active-high. All outputs are registered.
- Reset values: S_n=1, R_n=1, CmdReady=0, Done=0, Error=0, ErrCount=0, state=IDLE, counter=0.
- CmdReady rises on the first edge after Reset deasserts.
- FSM states: IDLE, PULSE, SETTLE, CHECK.
- IDLE:
  - CmdReady=1.
  - Accept occurs at edge k when CmdValid=1 and CmdReady=1.
  - On accept: latch CmdSet, CmdReady->0, Error->0, counter<=PULSE_CYCLES-1, go to PULSE.
- PULSE:
  - Set commands drive S_n=0; clear commands drive R_n=0; the other strobe stays at 1.
  - The strobe is low for exactly PULSE_CYCLES cycles: edge k+1 through edge k+PULSE_CYCLES.
  - When counter==0: release the strobe, counter<=SETTLE_CYCLES-1, go to SETTLE.
- SETTLE:
  - S_n=R_n=1.
  - Counts down; when counter==0, go to CHECK.
- CHECK: one cycle.
  - Sample Q_in/Qn_in.
  - Expected values: (1,0) for a set command, (0,1) for a clear command.
  - Any other value, including (1,1) or (0,0), is a mismatch.
- Result timing:
  - Done=1 and Error=mismatch for exactly one cycle, at edge k+PULSE_CYCLES+SETTLE_CYCLES+1.
  - On the same edge: CmdReady=1 and return to IDLE.
  - Back-to-back commands are allowed; the next accept can occur on the edge where Done is high.
- ErrCount increments by 1 on each mismatch and saturates at all-ones; it does not wrap.
- CmdValid is ignored while CmdReady=0 or Reset=1; there is no queuing.
- CmdSet is sampled only at accept; later changes have no effect.
- Reset mid-operation: on the next edge S_n=R_n=1, Done=0, Error=0, ErrCount=0, state IDLE. The aborted command produces no Done.
- Invariant: S_n and R_n are never both 0 in any cycle, including during reset.

Optional Feature:
- Macro: SR_LATCH_DRIVER_SYNC_EN.
- Defined:
  - Q_in and Qn_in each pass through a two-flop synchronizer before the CHECK sample.
  - SETTLE is extended by 2 cycles.
  - Done/Error arrive at edge k+PULSE_CYCLES+SETTLE_CYCLES+3.
- Undefined:
  - Q_in and Qn_in are sampled directly in CHECK.
  - Timing is as stated under Behaviour.

Test Plan:
- Reset, then idle:
  - Hold Reset for 3 cycles -> S_n=R_n=1, CmdReady=0, ErrCount=0.
  - First edge after release -> CmdReady=1.
- Set into the real latch (defaults, 10 ns Clk):
  - Accept CmdSet=1 at edge k -> S_n=0 for edges k+1..k+2.
  - Done=1 with Error=0 at edge k+6; latch Q=1, Qn=0.
- Clear following set:
  - Accept CmdSet=0 on the edge where the set's Done is high -> R_n=0 for 2 cycles.
  - Done with Error=0; Q=0, Qn=1; S_n never low during this command.
- Fault injection:
  - Force Q_in=0, Qn_in=0 and issue a set -> Done with Error=1, ErrCount=1.
  - Repeat 300 times -> ErrCount=255, no wrap.
- Reset mid-pulse:
  - Assert Reset at edge k+1 while S_n=0 -> S_n=1 at edge k+2, no Done, CmdReady=1 after release.
  - CmdValid held high during the busy window -> only one accept.
- Run with SR_LATCH_DRIVER_SYNC_EN defined, repeating the set case -> Done at edge k+8 with Error=0.
